dbus_ram: RTL and testbench
===========================

DBUS_RAM -- requirements
Module: dbus_ram

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words (power of two, 16..65536).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0 (DEPTH_WORDS*4 aligned).
REQ-003 SHALL have parameter WAIT_CYCLES, default 0, extra stall cycles per accepted command (0..15).
REQ-004 SHALL have ports:
- clk  in  1  sole clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- dBus_cmd_valid  in  1  command present.
- dBus_cmd_ready  out  1  command accepted when high with valid.
- dBus_cmd_payload_wr  in  1  1=write, 0=read.
- dBus_cmd_payload_mask  in  4  write byte enables, bit i = byte lane i.
- dBus_cmd_payload_address  in  32  byte address.
- dBus_cmd_payload_data  in  32  write data.
- dBus_cmd_payload_size  in  2  0=byte, 1=half, 2=word.
- dBus_rsp_ready  out  1  read response valid, one-cycle pulse.
- dBus_rsp_error  out  1  response carries error.
- dBus_rsp_data  out  32  read data.

Function
REQ-005 SHALL accept a command in any cycle with dBus_cmd_valid and dBus_cmd_ready both high ("accept cycle" N).
REQ-006 SHALL index word (address - BASE_ADDR)[log2(DEPTH_WORDS)+1:2]; address bits [1:0] SHALL NOT affect indexing.
REQ-007 Write: SHALL update only lanes with mask bit set, at the rising edge ending cycle N; mask 4'b0000 SHALL leave memory unchanged.
REQ-008 Write SHALL produce no response; dBus_rsp_ready SHALL stay low for writes.
REQ-009 Read: SHALL pulse dBus_rsp_ready high for exactly one cycle, cycle N+1+WAIT_CYCLES, with dBus_rsp_data = full word (all 4 lanes, size ignored).
REQ-010 State machine IDLE, STALL, RESP: IDLE has cmd_ready=1; accept write -> STALL if WAIT_CYCLES>0 else stay IDLE; accept read -> STALL if WAIT_CYCLES>0 else RESP; STALL counts WAIT_CYCLES cycles then -> IDLE (write) or RESP (read); RESP lasts one cycle -> IDLE.
REQ-011 dBus_cmd_ready SHALL be low in STALL and RESP; with WAIT_CYCLES=0, back-to-back writes SHALL be accepted every cycle and reads every second cycle.
REQ-012 dBus_rsp_data and dBus_rsp_error SHALL be 0 whenever dBus_rsp_ready is low.
REQ-013 Read data SHALL reflect all writes accepted in earlier cycles (read-after-write in consecutive cycles returns the new data).
REQ-014 Stall counter SHALL be 4 bits, loaded at accept, no wrap beyond WAIT_CYCLES.
REQ-015 Memory SHALL be zero-initialised at configuration.

Reset
REQ-016 While reset is high: state IDLE, stall counter 0, dBus_cmd_ready=0, dBus_rsp_ready=0, dBus_rsp_error=0, dBus_rsp_data=0.
REQ-017 First cycle after reset deasserts: dBus_cmd_ready=1.
REQ-018 Reset mid-operation SHALL discard any pending read response; no response SHALL be emitted for it after reset.
REQ-019 Reset SHALL NOT alter memory contents; a write whose accept edge coincides with reset assertion SHALL NOT be committed.

Configuration
REQ-020 Macro DBUS_RAM_ERR_CHECK_EN defined: a command is in error if address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4) or misaligned (size 1 with address[0]=1, size 2 with address[1:0]!=0); erroneous write SHALL be dropped; erroneous read SHALL respond with dBus_rsp_error=1, dBus_rsp_data=0, same timing as REQ-009.
REQ-021 Macro DBUS_RAM_ERR_CHECK_EN undefined: no checking, addresses wrap modulo DEPTH_WORDS*4, dBus_rsp_error tied 0.

Verification
REQ-022 Reset, release, idle -> cmd_ready=1 on first post-reset cycle, rsp_ready stays 0.
REQ-023 Write 0x1000 data 0xDEADBEEF mask 4'b1111, then read 0x1000 (WAIT_CYCLES=0) -> rsp_ready pulse at N+1, data 0xDEADBEEF, error 0.
REQ-024 Write 0x1000 data 0x000000AA mask 4'b0001 over 0xDEADBEEF, read -> 0xDEADBEAA; WAIT_CYCLES=3 -> rsp at N+4, cmd_ready low N+1..N+4.
REQ-025 ERR_CHECK_EN, read 0x0000_1002 size 2 -> rsp_error=1, data 0; write out of range 0x0001_0000 (DEPTH 1024) -> memory unchanged, no rsp.
REQ-026 Accept read with WAIT_CYCLES=5, assert reset at N+2 -> no rsp_ready pulse; memory word intact on next read.

Source files
------------

// File: rtl/dbus_ram.sv
`default_nettype none
// ============================================================================
// Module   : dbus_ram
// Brief    : Single-port word RAM on a VexRiscv-style dBus. Commands take an
//            optional fixed stall, and reads return one response pulse.
//            Optional macro DBUS_RAM_ERR_CHECK_EN enables range/alignment
//            error responses.
// Revision : 1.0
// ============================================================================
module dbus_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dBus_cmd_valid,
  output logic        dBus_cmd_ready,
  input  logic        dBus_cmd_payload_wr,
  input  logic [3:0]  dBus_cmd_payload_mask,
  input  logic [31:0] dBus_cmd_payload_address,
  input  logic [31:0] dBus_cmd_payload_data,
  input  logic [1:0]  dBus_cmd_payload_size,
  output logic        dBus_rsp_ready,
  output logic        dBus_rsp_error,
  output logic [31:0] dBus_rsp_data
);

  localparam int unsigned c_AW   = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  c_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STALL = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic              r_is_rd;
  logic [31:0]       r_rdata;
  logic [31:0]       r_mem [DEPTH_WORDS] = '{default: 32'h0};

  logic              w_accept;
  logic [31:0]       w_off;
  logic [c_AW-1:0]   w_idx;
  logic              w_cmd_err;
  logic              w_unused;

  assign w_accept = dBus_cmd_valid && dBus_cmd_ready;
  assign w_off    = dBus_cmd_payload_address - BASE_ADDR;
  assign w_idx    = w_off[c_AW+1:2];

`ifdef DBUS_RAM_ERR_CHECK_EN
  logic w_out_of_range;
  logic w_misaligned;
  logic r_err;

  // BASE_ADDR is aligned to the RAM size, so any set bit above the RAM span
  // (including wrap-around from addresses below BASE_ADDR) means out of range.
  assign w_out_of_range = |w_off[31:c_AW+2];
  assign w_misaligned   = ((dBus_cmd_payload_size == 2'd1) && dBus_cmd_payload_address[0]) ||
                          ((dBus_cmd_payload_size == 2'd2) && (dBus_cmd_payload_address[1:0] != 2'b00));
  assign w_cmd_err      = w_out_of_range || w_misaligned;
  assign w_unused       = ^w_off[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_cmd_err;
    end
  end

  assign dBus_rsp_error = dBus_rsp_ready && r_err;
`else
  assign w_cmd_err      = 1'b0;
  assign w_unused       = ^{w_off[31:c_AW+2], w_off[1:0], dBus_cmd_payload_size};
  assign dBus_rsp_error = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt = c_WAIT;
          if (c_WAIT != 4'd0) begin
            w_state_nxt = S_STALL;
          end else if (!dBus_cmd_payload_wr) begin
            w_state_nxt = S_RESP;
          end
        end
      end
      S_STALL: begin
        if (r_cnt <= 4'd1) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = r_is_rd ? S_RESP : S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_is_rd <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_is_rd <= !dBus_cmd_payload_wr;
      end
    end
  end

  // Memory is deliberately outside the reset domain; w_accept already
  // excludes cycles where reset is high, so a coinciding write is not committed.
  always_ff @(posedge clk) begin
    if (w_accept && dBus_cmd_payload_wr && !w_cmd_err) begin
      for (int i = 0; i < 4; i++) begin
        if (dBus_cmd_payload_mask[i]) begin
          r_mem[w_idx][8*i +: 8] <= dBus_cmd_payload_data[8*i +: 8];
        end
      end
    end
    if (w_accept && !dBus_cmd_payload_wr) begin
      r_rdata <= w_cmd_err ? 32'h0 : r_mem[w_idx];
    end
  end

  assign dBus_cmd_ready = (r_state == S_IDLE) && !reset;
  assign dBus_rsp_ready = (r_state == S_RESP);
  assign dBus_rsp_data  = dBus_rsp_ready ? r_rdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_dbus_ram.sv
`default_nettype none
// Bench for dbus_ram: two instances (no stall, 3-cycle stall) driven with
// directed and random commands, checked against a word-array reference model.
module tb_dbus_ram;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst  [2];
  logic        vld  [2];
  logic        wr   [2];
  logic [3:0]  msk  [2];
  logic [31:0] adr  [2];
  logic [31:0] dat  [2];
  logic [1:0]  sz   [2];
  logic        crdy [2];
  logic        rrdy [2];
  logic        rerr [2];
  logic [31:0] rdat [2];

  logic [31:0] ref_mem [2][DEPTH];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dbus_ram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(rst[0]),
    .dBus_cmd_valid(vld[0]), .dBus_cmd_ready(crdy[0]),
    .dBus_cmd_payload_wr(wr[0]), .dBus_cmd_payload_mask(msk[0]),
    .dBus_cmd_payload_address(adr[0]), .dBus_cmd_payload_data(dat[0]),
    .dBus_cmd_payload_size(sz[0]),
    .dBus_rsp_ready(rrdy[0]), .dBus_rsp_error(rerr[0]), .dBus_rsp_data(rdat[0])
  );

  dbus_ram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .reset(rst[1]),
    .dBus_cmd_valid(vld[1]), .dBus_cmd_ready(crdy[1]),
    .dBus_cmd_payload_wr(wr[1]), .dBus_cmd_payload_mask(msk[1]),
    .dBus_cmd_payload_address(adr[1]), .dBus_cmd_payload_data(dat[1]),
    .dBus_cmd_payload_size(sz[1]),
    .dBus_rsp_ready(rrdy[1]), .dBus_rsp_error(rerr[1]), .dBus_rsp_data(rdat[1])
  );

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off / 4) % DEPTH);
  endfunction

  function automatic bit is_err(input logic [31:0] a, input logic [1:0] s);
    logic [31:0] off;
    bit          e;
    off = a - BASE;
    e   = (off >= DEPTH * 4) || (s == 2'd1 && (a % 2) != 0) || (s == 2'd2 && (a % 4) != 0);
`ifdef DBUS_RAM_ERR_CHECK_EN
    return e;
`else
    return 1'b0 & e;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input int k, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] m, input logic [1:0] s);
    int i;
    logic [31:0] w;
    if (!is_err(a, s)) begin
      i = widx(a);
      w = ref_mem[k][i];
      for (int b = 0; b < 4; b++) begin
        if (m[b]) w[8*b +: 8] = d[8*b +: 8];
      end
      ref_mem[k][i] = w;
    end
  endtask

  // Issue one command, then check handshake/response timing cycle by cycle.
  task automatic issue(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic [1:0] s);
    int          n;
    int          wt;
    bit          e;
    bit          exp_rsp;
    logic [31:0] exp_data;
    wt = wait_of(k);
    @(negedge clk);
    vld[k] = 1'b1; wr[k] = w; adr[k] = a; dat[k] = d; msk[k] = m; sz[k] = s;
    n = 0;
    while (crdy[k] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check($sformatf("accept_timeout_d%0d", k), 32'(crdy[k]), 32'd1);
      vld[k] = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      vld[k] = 1'b0;
      e = is_err(a, s);
      exp_data = e ? 32'h0 : ref_mem[k][widx(a)];
      if (w) model_write(k, a, d, m, s);
      for (int j = 1; j <= wt + 2; j++) begin
        @(negedge clk);
        exp_rsp = !w && (j == wt + 1);
        check($sformatf("cmd_ready_d%0d_j%0d", k, j), 32'(crdy[k]), (j <= wt || exp_rsp) ? 32'd0 : 32'd1);
        check($sformatf("rsp_ready_d%0d_j%0d", k, j), 32'(rrdy[k]), 32'(exp_rsp));
        check($sformatf("rsp_data_d%0d_a%h", k, a), rdat[k], exp_rsp ? exp_data : 32'h0);
        check($sformatf("rsp_error_d%0d", k), 32'(rerr[k]), 32'(exp_rsp && e));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  s;
    int          k;
    int          r;

    for (int q = 0; q < 2; q++) begin
      rst[q] = 1'b1; vld[q] = 1'b0; wr[q] = 1'b0; msk[q] = 4'h0;
      adr[q] = 32'h0; dat[q] = 32'h0; sz[q] = 2'd0;
      for (int i = 0; i < DEPTH; i++) ref_mem[q][i] = 32'h0;
    end

    // Reset state and first post-reset cycle
    repeat (2) @(negedge clk);
    for (int q = 0; q < 2; q++) begin
      check($sformatf("rst_cmd_ready_d%0d", q), 32'(crdy[q]), 32'd0);
      check($sformatf("rst_rsp_ready_d%0d", q), 32'(rrdy[q]), 32'd0);
      check($sformatf("rst_rsp_data_d%0d", q), rdat[q], 32'h0);
      check($sformatf("rst_rsp_error_d%0d", q), 32'(rerr[q]), 32'd0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    #1;
    for (int q = 0; q < 2; q++) check($sformatf("post_rst_cmd_ready_d%0d", q), 32'(crdy[q]), 32'd1);
    repeat (3) begin
      @(negedge clk);
      for (int q = 0; q < 2; q++) check($sformatf("idle_rsp_ready_d%0d", q), 32'(rrdy[q]), 32'd0);
    end

    // Unwritten memory reads as zero; word write then read, then byte-lane merge
    issue(0, 1'b0, 32'h0000_1040, 32'h0, 4'h0, 2'd2);
    issue(0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b1111, 2'd2);
    issue(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 2'd2);
    issue(1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b1111, 2'd2);
    issue(1, 1'b1, 32'h0000_1000, 32'h0000_00AA, 4'b0001, 2'd0);
    issue(1, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 2'd2);
    issue(0, 1'b1, 32'h0000_1003, 32'h1234_5678, 4'b0000, 2'd0);
    issue(0, 1'b0, 32'h0000_1001, 32'h0, 4'h0, 2'd0);

    // Misaligned read and out-of-range write (error or wrap per build)
    issue(0, 1'b0, 32'h0000_1002, 32'h0, 4'h0, 2'd2);
    issue(0, 1'b1, 32'h0001_0000, 32'h1234_5678, 4'b1111, 2'd2);
    issue(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 2'd2);

    // Back-to-back on the no-stall instance: writes every cycle, reads every other
    @(negedge clk);
    vld[0] = 1'b1; wr[0] = 1'b1; adr[0] = 32'h0000_1010; dat[0] = 32'h1111_2222; msk[0] = 4'hF; sz[0] = 2'd2;
    check("b2b_wr0_ready", 32'(crdy[0]), 32'd1);
    @(posedge clk); #1;
    model_write(0, 32'h0000_1010, 32'h1111_2222, 4'hF, 2'd2);
    adr[0] = 32'h0000_1014; dat[0] = 32'h3333_4444;
    @(negedge clk);
    check("b2b_wr1_ready", 32'(crdy[0]), 32'd1);
    check("b2b_wr1_rsp", 32'(rrdy[0]), 32'd0);
    @(posedge clk); #1;
    model_write(0, 32'h0000_1014, 32'h3333_4444, 4'hF, 2'd2);
    wr[0] = 1'b0; adr[0] = 32'h0000_1010;
    @(negedge clk);
    check("b2b_rd0_ready", 32'(crdy[0]), 32'd1);
    @(posedge clk); #1;
    adr[0] = 32'h0000_1014;
    @(negedge clk);
    check("b2b_rd1_blocked", 32'(crdy[0]), 32'd0);
    check("b2b_rd0_rsp", 32'(rrdy[0]), 32'd1);
    check("b2b_rd0_data", rdat[0], ref_mem[0][widx(32'h0000_1010)]);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_rd1_ready", 32'(crdy[0]), 32'd1);
    check("b2b_rd1_norsp", 32'(rrdy[0]), 32'd0);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    @(negedge clk);
    check("b2b_rd1_rsp", 32'(rrdy[0]), 32'd1);
    check("b2b_rd1_data", rdat[0], ref_mem[0][widx(32'h0000_1014)]);

    // Reset during the stall of a pending read discards the response
    @(negedge clk);
    vld[1] = 1'b1; wr[1] = 1'b0; adr[1] = 32'h0000_1000; sz[1] = 2'd2;
    check("rst_mid_accept_ready", 32'(crdy[1]), 32'd1);
    @(posedge clk); #1;
    vld[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst[1] = 1'b1;
    #1;
    check("rst_mid_cmd_ready", 32'(crdy[1]), 32'd0);
    check("rst_mid_rsp_ready", 32'(rrdy[1]), 32'd0);
    repeat (2) @(negedge clk);
    rst[1] = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check($sformatf("rst_mid_no_rsp_%0d", j), 32'(rrdy[1]), 32'd0);
      check($sformatf("rst_mid_idle_ready_%0d", j), 32'(crdy[1]), 32'd1);
    end
    issue(1, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 2'd2);

    // Random traffic on a small window so reads frequently hit written words
    for (int t = 0; t < 80; t++) begin
      k = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      s = 2'($urandom_range(0, 2));
      if (r < 7)       a = BASE + 32'($urandom_range(0, 15) * 4);
      else if (r < 9)  a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      else             a = $urandom;
      issue(k, ($urandom_range(0, 1) == 1), a, $urandom, 4'($urandom_range(0, 15)), s);
    end
    for (int i = 0; i < 16; i++) issue(i % 2, 1'b0, BASE + 32'(i * 4), 32'h0, 4'h0, 2'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
